// File: rtl/noc_pkg.sv
// Shared NoC flit layout and the reducer's home location.
// Also holds the classification helper used by the ingress filter.
package noc_pkg;

  localparam int FLIT_W   = 36;
  localparam int HDR_W    = 4;
  localparam int HDR_X_HI = 3;
  localparam int HDR_X_LO = 2;
  localparam int HDR_Y_HI = 1;
  localparam int HDR_Y_LO = 0;

  localparam logic [HDR_W-1:0] REDUCER_LOC = 4'b1101;

  typedef enum logic [1:0] {
    FLIT_DROP     = 2'd0,
    FLIT_ACCEPT   = 2'd1,
    FLIT_MISROUTE = 2'd2
  } flit_kind_e;

  function automatic logic [HDR_W-1:0] make_hdr(input logic [1:0] x, input logic [1:0] y);
    logic [HDR_W-1:0] h;
    h                   = '0;
    h[HDR_X_HI:HDR_X_LO] = x;
    h[HDR_Y_HI:HDR_Y_LO] = y;
    return h;
  endfunction

  // Empty flits (null header or zero payload) are idle filler, not errors.
  function automatic flit_kind_e classify(input logic [HDR_W-1:0] hdr,
                                          input logic [HDR_W-1:0] own,
                                          input logic             payload_nz);
    if (hdr == '0 || !payload_nz) return FLIT_DROP;
    else if (hdr == own)          return FLIT_ACCEPT;
    else                          return FLIT_MISROUTE;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// First-word-fall-through synchronous FIFO with occupancy count and flush.
// Pointers wrap modulo DEPTH, which must be a power of two.
module sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8,
  parameter int PTR   = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_flush,
  input  logic             i_wr_en,
  input  logic [WIDTH-1:0] i_wr_data,
  input  logic             i_rd_en,
  output logic [WIDTH-1:0] o_rd_data,
  output logic [PTR:0]     o_count,
  output logic             o_full,
  output logic             o_empty
);

  localparam logic [PTR:0] FULL_CNT = (PTR+1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR-1:0]   r_wr_ptr;
  logic [PTR-1:0]   r_rd_ptr;
  logic [PTR:0]     r_count;
  logic             w_push;
  logic             w_pop;

  assign o_full  = (r_count == FULL_CNT);
  assign o_empty = (r_count == '0);
  assign w_push  = i_wr_en & ~o_full;
  assign w_pop   = i_rd_en & ~o_empty;

  // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst || i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // NOTE: storage has no reset; count gates validity, so stale contents are never observed.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_wr_data;
  end

  // Head entry is never overwritten while valid: a non-full FIFO keeps wr_ptr off rd_ptr.
  assign o_rd_data = r_mem[r_rd_ptr];
  assign o_count   = r_count;

endmodule

// File: rtl/reducer_ingress.sv
// Reducer ingress: filters flits from the router local port by header,
// buffers accepted payloads in a FWFT FIFO and keeps traffic statistics.
module reducer_ingress
  import noc_pkg::*;
#(
  parameter int WIDTH = FLIT_W,
  parameter int DEPTH = 8,
  parameter int PTR   = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [1:0]         noc_locationx,
  input  logic [1:0]         noc_locationy,
  input  logic [WIDTH-1:0]   Data_in,
  input  logic               Data_in_valid,
  output logic               Data_in_ready,
  output logic [WIDTH-5:0]   Data_out,
  output logic               Data_out_valid,
  input  logic               Data_out_ready,
  input  logic               flush,
  output logic [PTR:0]       fifo_count,
  output logic [15:0]        word_count,
  output logic [7:0]         misroute_count,
  output logic               misroute_err
);

  logic       w_full;
  logic       w_empty;
  logic       w_transfer;
  logic       w_push;
  logic       w_misroute;
  flit_kind_e w_kind;

  logic [15:0] r_word_count;
  logic [7:0]  r_misroute_count;
  logic        r_misroute_err;

  // Ready depends only on the registered count, never on Data_out_ready.
  assign Data_in_ready  = ~w_full;
  assign Data_out_valid = ~w_empty;
  assign w_transfer     = Data_in_valid & Data_in_ready;
  assign w_kind         = classify(Data_in[HDR_W-1:0],
                                   make_hdr(noc_locationx, noc_locationy),
                                   |Data_in[WIDTH-1:HDR_W]);
  assign w_push         = w_transfer && (w_kind == FLIT_ACCEPT);
  assign w_misroute     = w_transfer && (w_kind == FLIT_MISROUTE);

  sync_fifo #(
    .WIDTH (WIDTH - HDR_W),
    .DEPTH (DEPTH),
    .PTR   (PTR)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .i_flush   (flush),
    .i_wr_en   (w_push),
    .i_wr_data (Data_in[WIDTH-1:HDR_W]),
    .i_rd_en   (Data_out_ready),
    .o_rd_data (Data_out),
    .o_count   (fifo_count),
    .o_full    (w_full),
    .o_empty   (w_empty)
  );

  // Counters track accepted traffic even when a flush discards the word.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_word_count     <= '0;
      r_misroute_count <= '0;
      r_misroute_err   <= 1'b0;
    end else begin
      if (w_push && r_word_count != 16'hFFFF)
        r_word_count <= r_word_count + 16'd1;
      if (w_misroute && r_misroute_count != 8'hFF)
        r_misroute_count <= r_misroute_count + 8'd1;
      r_misroute_err <= w_misroute;
    end
  end

  assign word_count     = r_word_count;
  assign misroute_count = r_misroute_count;
  assign misroute_err   = r_misroute_err;

endmodule

// File: tb/tb_reducer_ingress.sv
// Directed bench for reducer_ingress: a vector table for single-flit behaviour
// plus hand-written sequences for fill/wrap, flush, reset and saturation.
module tb_reducer_ingress;

  localparam int WIDTH = 36;
  localparam int DEPTH = 8;
  localparam int PTR   = 3;
  localparam logic [3:0] OWN = 4'b1101;
  localparam logic [3:0] BAD = 4'b0110;

  logic             clk = 1'b0;
  logic             rst;
  logic [1:0]       noc_locationx;
  logic [1:0]       noc_locationy;
  logic [WIDTH-1:0] Data_in;
  logic             Data_in_valid;
  logic             Data_in_ready;
  logic [WIDTH-5:0] Data_out;
  logic             Data_out_valid;
  logic             Data_out_ready;
  logic             flush;
  logic [PTR:0]     fifo_count;
  logic [15:0]      word_count;
  logic [7:0]       misroute_count;
  logic             misroute_err;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  reducer_ingress #(.WIDTH(WIDTH), .DEPTH(DEPTH), .PTR(PTR)) dut (
    .clk            (clk),
    .rst            (rst),
    .noc_locationx  (noc_locationx),
    .noc_locationy  (noc_locationy),
    .Data_in        (Data_in),
    .Data_in_valid  (Data_in_valid),
    .Data_in_ready  (Data_in_ready),
    .Data_out       (Data_out),
    .Data_out_valid (Data_out_valid),
    .Data_out_ready (Data_out_ready),
    .flush          (flush),
    .fifo_count     (fifo_count),
    .word_count     (word_count),
    .misroute_count (misroute_count),
    .misroute_err   (misroute_err)
  );

  typedef struct {
    logic        vld;
    logic [3:0]  hdr;
    logic [31:0] pay;
    logic        rdy;
    logic [3:0]  exp_cnt;
    logic        exp_ov;
    logic [31:0] exp_dout;
    logic [15:0] exp_wc;
    logic [7:0]  exp_mc;
    logic        exp_err;
  } vec_t;

  vec_t vecs [8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [3:0] h, input logic [31:0] p);
    Data_in_valid = v;
    Data_in       = {p, h};
  endtask

  initial begin
    rst            = 1'b1;
    flush          = 1'b0;
    noc_locationx  = 2'd3;
    noc_locationy  = 2'd1;
    Data_out_ready = 1'b0;
    drive(1'b0, 4'h0, 32'd0);

    //          vld   hdr   pay    rdy   cnt  ov   dout   wc  mc  err
    vecs[0] = '{1'b1, OWN,  32'd0, 1'b1, 4'd0, 1'b0, 32'd0, 16'd0, 8'd0, 1'b0};
    vecs[1] = '{1'b1, 4'h0, 32'd7, 1'b1, 4'd0, 1'b0, 32'd0, 16'd0, 8'd0, 1'b0};
    vecs[2] = '{1'b1, OWN,  32'd1, 1'b1, 4'd1, 1'b1, 32'd1, 16'd1, 8'd0, 1'b0};
    vecs[3] = '{1'b1, OWN,  32'd2, 1'b1, 4'd1, 1'b1, 32'd2, 16'd2, 8'd0, 1'b0};
    vecs[4] = '{1'b1, OWN,  32'd3, 1'b1, 4'd1, 1'b1, 32'd3, 16'd3, 8'd0, 1'b0};
    vecs[5] = '{1'b0, OWN,  32'd0, 1'b1, 4'd0, 1'b0, 32'd0, 16'd3, 8'd0, 1'b0};
    vecs[6] = '{1'b1, BAD,  32'd5, 1'b1, 4'd0, 1'b0, 32'd0, 16'd3, 8'd1, 1'b1};
    vecs[7] = '{1'b0, BAD,  32'd0, 1'b1, 4'd0, 1'b0, 32'd0, 16'd3, 8'd1, 1'b0};

    step();
    step();
    check("reset count", 32'(fifo_count), 32'd0);
    check("reset out_valid", 32'(Data_out_valid), 32'd0);
    check("reset in_ready", 32'(Data_in_ready), 32'd1);
    check("reset word_count", 32'(word_count), 32'd0);
    check("reset misroute_count", 32'(misroute_count), 32'd0);
    check("reset misroute_err", 32'(misroute_err), 32'd0);
    rst = 1'b0;

    // Discards, three in-order words with one-cycle latency, one misroute.
    for (int i = 0; i < 8; i++) begin
      drive(vecs[i].vld, vecs[i].hdr, vecs[i].pay);
      Data_out_ready = vecs[i].rdy;
      step();
      check($sformatf("vec%0d count", i), 32'(fifo_count), 32'(vecs[i].exp_cnt));
      check($sformatf("vec%0d out_valid", i), 32'(Data_out_valid), 32'(vecs[i].exp_ov));
      if (vecs[i].exp_ov)
        check($sformatf("vec%0d data_out", i), Data_out, vecs[i].exp_dout);
      check($sformatf("vec%0d word_count", i), 32'(word_count), 32'(vecs[i].exp_wc));
      check($sformatf("vec%0d misroute_count", i), 32'(misroute_count), 32'(vecs[i].exp_mc));
      check($sformatf("vec%0d misroute_err", i), 32'(misroute_err), 32'(vecs[i].exp_err));
      check($sformatf("vec%0d in_ready", i), 32'(Data_in_ready), 32'(vecs[i].exp_cnt != 4'd8));
    end

    // Fill to full with the reducer stalled; head must stay stable.
    Data_out_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, OWN, 32'(10 + i));
      step();
      check($sformatf("fill%0d count", i), 32'(fifo_count), 32'(i + 1));
      check($sformatf("fill%0d in_ready", i), 32'(Data_in_ready), (i == 7) ? 32'd0 : 32'd1);
      check($sformatf("fill%0d head", i), Data_out, 32'd10);
    end
    drive(1'b1, OWN, 32'd18);
    step();
    check("full hold count", 32'(fifo_count), 32'd8);
    check("full hold word_count", 32'(word_count), 32'd11);
    check("full hold head", Data_out, 32'd10);
    // Pop while full: ready was low, so the 9th flit must wait.
    Data_out_ready = 1'b1;
    step();
    check("pop at full count", 32'(fifo_count), 32'd7);
    check("pop at full in_ready", 32'(Data_in_ready), 32'd1);
    check("pop at full head", Data_out, 32'd11);
    check("pop at full word_count", 32'(word_count), 32'd11);
    Data_out_ready = 1'b0;
    step();
    check("9th accepted count", 32'(fifo_count), 32'd8);
    check("9th accepted word_count", 32'(word_count), 32'd12);
    drive(1'b0, OWN, 32'd0);
    Data_out_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      check($sformatf("drain%0d data", k), Data_out, 32'(11 + k));
      step();
    end
    check("drained count", 32'(fifo_count), 32'd0);
    check("drained out_valid", 32'(Data_out_valid), 32'd0);

    // Flush with simultaneous push and pop.
    Data_out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, OWN, 32'(20 + i));
      step();
    end
    check("pre-flush count", 32'(fifo_count), 32'd4);
    check("pre-flush word_count", 32'(word_count), 32'd16);
    drive(1'b1, OWN, 32'd24);
    Data_out_ready = 1'b1;
    flush = 1'b1;
    step();
    flush = 1'b0;
    check("flush count", 32'(fifo_count), 32'd0);
    check("flush out_valid", 32'(Data_out_valid), 32'd0);
    check("flush word_count", 32'(word_count), 32'd17);
    check("flush misroute_count", 32'(misroute_count), 32'd1);
    drive(1'b0, OWN, 32'd0);
    Data_out_ready = 1'b0;
    step();
    check("post-flush count", 32'(fifo_count), 32'd0);

    // Reset with 5 words buffered and a flit on the input.
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, OWN, 32'(40 + i));
      step();
    end
    check("pre-reset count", 32'(fifo_count), 32'd5);
    check("pre-reset word_count", 32'(word_count), 32'd22);
    rst = 1'b1;
    drive(1'b1, OWN, 32'd50);
    step();
    rst = 1'b0;
    drive(1'b0, OWN, 32'd0);
    check("mid reset count", 32'(fifo_count), 32'd0);
    check("mid reset out_valid", 32'(Data_out_valid), 32'd0);
    check("mid reset in_ready", 32'(Data_in_ready), 32'd1);
    check("mid reset word_count", 32'(word_count), 32'd0);
    check("mid reset misroute_count", 32'(misroute_count), 32'd0);
    check("mid reset misroute_err", 32'(misroute_err), 32'd0);
    step();
    check("post reset word_count", 32'(word_count), 32'd0);
    check("post reset count", 32'(fifo_count), 32'd0);

    // Misroute counter saturation.
    drive(1'b1, BAD, 32'd1);
    repeat (255) step();
    check("misroute 255", 32'(misroute_count), 32'd255);
    check("misroute err held", 32'(misroute_err), 32'd1);
    check("misroute no write", 32'(fifo_count), 32'd0);
    step();
    check("misroute saturated", 32'(misroute_count), 32'd255);
    drive(1'b0, BAD, 32'd0);
    step();
    check("misroute err clear", 32'(misroute_err), 32'd0);
    check("misroute word_count", 32'(word_count), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
